cache_refill_unit: RTL and testbench
====================================

Name: cache_refill_unit

Overview:
Miss-handling stage that sits directly upstream of the cache-side read port of the CPU AXI bridge. It accepts one line-miss request from the cache, issues LINE_WORDS single-word reads in critical-word-first wrap order, and assembles the beats into a line buffer. It signals the critical word early, then presents the full line to the cache for a one-cycle write-back.

Parameters:
LINE_WORDS, 4, words per cache line; power of two, at least 2.
OFF_W, $clog2(LINE_WORDS)+2, byte-offset width within a line (derived; not overridden).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
miss_valid  in  1  cache requests a line refill
miss_addr  in  32  byte address of the missing access
miss_ready  out  1  unit idle; miss accepted when miss_valid && miss_ready
crit_valid  out  1  one-cycle pulse: critical word returned
crit_data  out  32  critical word, valid with crit_valid
refill_valid  out  1  one-cycle pulse: line complete
refill_addr  out  32  line-aligned address; low OFF_W bits are 0
refill_line  out  32*LINE_WORDS  word i at bits [32*i+31:32*i]
cache_rreq  out  1  read request to bridge
cache_rtype  out  2  access size; constant 2'b10 (word)
cache_raddr  out  32  word-aligned beat address
cache_rready  out  1  ready to take read data
cache_arready  in  1  bridge accepted the request
cache_rvalid  in  1  read data beat valid
cache_rlast  in  1  last beat (single-beat reads, always 1; ignored)
cache_rdata  in  32  read data

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset forces IDLE and clears beat counter, line buffer, and all outputs. Reset state of outputs: miss_ready=1, all other outputs 0 except cache_rtype=2'b10.
- IDLE: miss_ready=1. On miss_valid, latch base=miss_addr[31:OFF_W] and start=miss_addr[OFF_W-1:2], set cnt=0, go to REQ.
- REQ: cache_rreq=1. cache_raddr={base, (start+cnt) mod LINE_WORDS, 2'b00}, held stable while in REQ. When cache_arready=1 at an edge, go to WAIT; cache_rreq drops the next cycle. A request must never be held across the accepting edge, because the bridge re-latches its address while cache_rreq is high.
- WAIT: cache_rready=1, cache_rreq=0. On cache_rvalid, write cache_rdata into line word (start+cnt) mod LINE_WORDS.
  - If cnt==0, pulse crit_valid with crit_data=cache_rdata in the same cycle as the capture (combinational from cache_rvalid while in WAIT with cnt==0).
  - If cnt==LINE_WORDS-1, go to DONE; otherwise cnt++ and go to REQ.
- DONE: refill_valid=1 for exactly one cycle, refill_addr={base, OFF_W'b0}, refill_line=buffer, then go to IDLE.
  - refill_line and refill_addr hold their values until the next accepted miss.
- Word index arithmetic is modulo LINE_WORDS (wrap). Example: LINE_WORDS=4, start=2 gives order 2,3,0,1.
- miss_ready=0 in REQ, WAIT and DONE. miss_valid in these states is ignored and not queued.
- cache_rvalid outside WAIT is ignored. cache_arready outside REQ is ignored.
- Latency: minimum 2 cycles per beat. From the acceptance edge to refill_valid is at least 2*LINE_WORDS+1 cycles.
- Reset mid-refill aborts immediately: no refill_valid, partial line discarded.

Decomposition:
- Shared package: FSM state enum, CACHE_RTYPE_WORD=2'b10 constant, line-width helper function.
- No sub-module is needed. The line buffer is an array of LINE_WORDS 32-bit registers inside the block.

Test Plan:
1. LINE_WORDS=4, miss_addr=0x1C00_0008, bridge returns addr+0x100 as data with zero-wait arready -> cache_raddr sequence 0x1C000008, 0x1C00000C, 0x1C000000, 0x1C000004.
   - crit_data=0x1C000108; refill_addr=0x1C000000.
   - refill_line[31:0]=0x1C000100, refill_line[127:96]=0x1C00010C.
   - refill_valid arrives 9 cycles after acceptance.
2. Hold cache_arready=0 for 3 cycles on beat 1 -> cache_rreq stays 1 and cache_raddr stays 0x1C00000C across all 3 cycles; exactly 4 requests are issued in total.
3. Assert miss_valid with miss_addr=0x2000_0000 during an active refill -> miss_ready=0, no new request; after refill_valid, the next miss is accepted from IDLE.
4. Assert reset while in WAIT on beat 2 -> all outputs return to reset values the same cycle; no refill_valid; a fresh miss refills correctly afterwards.
5. Aligned miss 0x1C00_0000 -> read order 0,1,2,3; crit_valid fires on the first beat only.
6. Inject a spurious cache_rvalid while in REQ -> line buffer unchanged and cnt unchanged.

Source files
------------

// File: rtl/cache_refill_unit_pkg.sv
// Shared types for the cache line refill unit.
// FSM state encoding, request-size constant and line-width helper.
package cache_refill_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] CACHE_RTYPE_WORD = 2'b10;

  function automatic int line_bits(input int words);
    return 32 * words;
  endfunction

endpackage

// File: rtl/cache_refill_unit.sv
// Line refill: one miss in, LINE_WORDS wrap-ordered word reads out.
// Ports: miss_* from cache, crit_*/refill_* to cache, cache_r* to bridge.
module cache_refill_unit
  import cache_refill_unit_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               miss_valid,
  input  logic [31:0]                        miss_addr,
  output logic                               miss_ready,
  output logic                               crit_valid,
  output logic [31:0]                        crit_data,
  output logic                               refill_valid,
  output logic [31:0]                        refill_addr,
  output logic [line_bits(LINE_WORDS)-1:0]   refill_line,
  output logic                               cache_rreq,
  output logic [1:0]                         cache_rtype,
  output logic [31:0]                        cache_raddr,
  output logic                               cache_rready,
  input  logic                               cache_arready,
  input  logic                               cache_rvalid,
  input  logic                               cache_rlast,
  input  logic [31:0]                        cache_rdata
);

  localparam int OFF_W = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W = OFF_W - 2;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(LINE_WORDS - 1);

  state_t            state;
  state_t            nxt;
  logic [31-OFF_W:0] base;
  logic [IDX_W-1:0]  start;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       line_q [LINE_WORDS];

  // Single-beat reads; the last flag carries no information.
  logic unused_rlast;
  assign unused_rlast = cache_rlast;

  // IDX_W-bit add wraps naturally modulo LINE_WORDS.
  assign idx = start + cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      base  <= '0;
      start <= '0;
      cnt   <= '0;
      for (int i = 0; i < LINE_WORDS; i++)
        line_q[i] <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: begin
          if (miss_valid) begin
            base  <= miss_addr[31:OFF_W];
            start <= miss_addr[OFF_W-1:2];
            cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (cache_rvalid) begin
            line_q[idx] <= cache_rdata;
            if (cnt != LAST)
              cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt          = state;
    miss_ready   = 1'b0;
    cache_rreq   = 1'b0;
    cache_rready = 1'b0;
    crit_valid   = 1'b0;
    refill_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid)
          nxt = S_REQ;
      end
      S_REQ: begin
        cache_rreq = 1'b1;
        if (cache_arready)
          nxt = S_WAIT;
      end
      S_WAIT: begin
        cache_rready = 1'b1;
        if (cache_rvalid) begin
          crit_valid = (cnt == '0);
          nxt = (cnt == LAST) ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        refill_valid = 1'b1;
        nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign cache_rtype = CACHE_RTYPE_WORD;
  assign cache_raddr = cache_rreq ? {base, idx, 2'b00} : '0;
  assign crit_data   = crit_valid ? cache_rdata : '0;
  // Line outputs track base/buffer, so they stay put until the
  // next miss is accepted and its beats start landing.
  assign refill_addr = {base, {OFF_W{1'b0}}};

  always_comb begin
    refill_line = '0;
    for (int i = 0; i < LINE_WORDS; i++)
      refill_line[32*i +: 32] = line_q[i];
  end

endmodule

// File: tb/tb_cache_refill_unit.sv
// Bench for cache_refill_unit: reactive bridge model, table and random
// misses, checked against a wrap-order reference computed arithmetically.
module tb_cache_refill_unit;

  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              miss_valid = 1'b0;
  logic [31:0]       miss_addr = '0;
  logic              miss_ready;
  logic              crit_valid;
  logic [31:0]       crit_data;
  logic              refill_valid;
  logic [31:0]       refill_addr;
  logic [32*LW-1:0]  refill_line;
  logic              cache_rreq;
  logic [1:0]        cache_rtype;
  logic [31:0]       cache_raddr;
  logic              cache_rready;
  logic              cache_arready = 1'b0;
  logic              cache_rvalid = 1'b0;
  logic              cache_rlast = 1'b1;
  logic [31:0]       cache_rdata = '0;

  cache_refill_unit #(.LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_ready(miss_ready),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .refill_valid(refill_valid), .refill_addr(refill_addr),
    .refill_line(refill_line),
    .cache_rreq(cache_rreq), .cache_rtype(cache_rtype),
    .cache_raddr(cache_raddr), .cache_rready(cache_rready),
    .cache_arready(cache_arready), .cache_rvalid(cache_rvalid),
    .cache_rlast(cache_rlast), .cache_rdata(cache_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          stall_idx;
    int          stall_len;
    bit          spur;
    bit          intrude;
    int          exp_lat;
    logic [31:0] exp_crit;
    logic [31:0] exp_raddr0;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          accepts, beats, crit_cnt, refill_cnt;
  bit          acc_seen, refill_seen, pending;
  int          acc_cyc, ref_cyc;
  logic [31:0] pend_addr, crit_cap, ref_addr_cap;
  logic [32*LW-1:0] ref_line_cap;
  logic [31:0] reqq[$];

  int          stall_idx = -1;
  int          stall_len = 0;
  int          rv_block_at = -1;
  int          wleft = -1;
  bit          spur = 0;
  bit          rand_mode = 0;
  logic [31:0] salt = '0;

  bit          prev_stall = 0;
  bit          prev_acc = 0;
  logic [31:0] prev_raddr = '0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a + 32'h100) ^ salt;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic bridge();
    cache_arready = 1'b0;
    cache_rvalid  = 1'b0;
    cache_rdata   = '0;
    if (reset) begin
      wleft = -1;
      return;
    end
    if (cache_rreq) begin
      if (wleft < 0) begin
        if (reqq.size() == stall_idx) wleft = stall_len;
        else if (rand_mode) wleft = int'($urandom_range(0, 2));
        else wleft = 0;
      end
      if (wleft == 0) begin
        cache_arready = 1'b1;
        wleft = -1;
      end else begin
        wleft--;
      end
    end
    if (pending && cache_rready && beats != rv_block_at &&
        (!rand_mode || $urandom_range(0, 1) == 1)) begin
      cache_rvalid = 1'b1;
      cache_rdata  = data_of(pend_addr);
    end else if (spur && !cache_rready) begin
      cache_rvalid = 1'b1;
      cache_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic monitor();
    cyc++;
    if (reset) begin
      pending = 0;
      prev_stall = 0;
      prev_acc = 0;
      return;
    end
    if (prev_stall) begin
      chk("req_held", 32'(cache_rreq), 32'd1);
      chk("raddr_held", cache_raddr, prev_raddr);
    end
    if (prev_acc)
      chk("req_dropped", 32'(cache_rreq), 32'd0);
    if (cache_rreq)
      chk("rtype", 32'(cache_rtype), 32'd2);
    prev_stall = cache_rreq && !cache_arready;
    prev_acc   = cache_rreq && cache_arready;
    prev_raddr = cache_raddr;
    if (miss_valid && miss_ready) begin
      acc_seen = 1;
      acc_cyc = cyc;
      accepts++;
    end
    if (cache_rreq && cache_arready) begin
      reqq.push_back(cache_raddr);
      pending = 1;
      pend_addr = cache_raddr;
    end
    if (cache_rvalid && cache_rready) begin
      pending = 0;
      beats++;
    end
    if (crit_valid) begin
      crit_cnt++;
      crit_cap = crit_data;
    end
    if (refill_valid) begin
      refill_cnt++;
      refill_seen = 1;
      ref_cyc = cyc;
      ref_addr_cap = refill_addr;
      ref_line_cap = refill_line;
    end
  endtask

  // Entered at a negedge with inputs for this cycle already set.
  task automatic step();
    bridge();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic clear_obs();
    reqq.delete();
    accepts = 0; beats = 0; crit_cnt = 0; refill_cnt = 0;
    acc_seen = 0; refill_seen = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_miss_ready"}, 32'(miss_ready), 32'd1);
    chk({tag, "_crit_valid"}, 32'(crit_valid), 32'd0);
    chk({tag, "_crit_data"}, crit_data, 32'd0);
    chk({tag, "_refill_valid"}, 32'(refill_valid), 32'd0);
    chk({tag, "_refill_addr"}, refill_addr, 32'd0);
    chk({tag, "_refill_line"}, 32'(|refill_line), 32'd0);
    chk({tag, "_rreq"}, 32'(cache_rreq), 32'd0);
    chk({tag, "_rtype"}, 32'(cache_rtype), 32'd2);
    chk({tag, "_raddr"}, cache_raddr, 32'd0);
    chk({tag, "_rready"}, 32'(cache_rready), 32'd0);
  endtask

  task automatic run_miss(input vec_t v, input bit use_tbl);
    logic [31:0] base;
    int          st;
    int          n;
    int          lat;
    base = v.addr & ~32'(LW*4 - 1);
    st   = int'((v.addr >> 2) % LW);
    stall_idx = v.stall_idx;
    stall_len = v.stall_len;
    spur = v.spur;
    clear_obs();
    miss_valid = 1'b1;
    miss_addr  = v.addr;
    n = 0;
    while (!acc_seen && n < 50) begin
      step();
      n++;
    end
    chk("accepted", 32'(acc_seen), 32'd1);
    if (v.intrude) miss_addr = 32'h2000_0000;
    else miss_valid = 1'b0;
    n = 0;
    while (!refill_seen && n < 400) begin
      if (v.intrude)
        chk("busy_miss_ready", 32'(miss_ready), 32'd0);
      step();
      n++;
    end
    miss_valid = 1'b0;
    chk("refill_seen", 32'(refill_seen), 32'd1);
    step();
    chk("refill_pulses", refill_cnt, 32'd1);
    chk("accepts", accepts, 32'd1);
    chk("nreq", reqq.size(), 32'(LW));
    for (int k = 0; k < LW; k++)
      if (k < reqq.size())
        chk($sformatf("raddr%0d", k), reqq[k],
            base + 32'(((st + k) % LW) * 4));
    for (int i = 0; i < LW; i++)
      chk($sformatf("line%0d", i), ref_line_cap[32*i +: 32],
          data_of(base + 32'(4*i)));
    chk("crit_cnt", crit_cnt, 32'd1);
    chk("crit_data", crit_cap, data_of(v.addr & ~32'h3));
    chk("refill_addr", ref_addr_cap, base);
    chk("refill_addr_hold", refill_addr, base);
    lat = ref_cyc - acc_cyc;
    if (v.exp_lat > 0) chk("latency", lat, v.exp_lat);
    else chk("latency_min", 32'(lat >= 2*LW + 1), 32'd1);
    if (use_tbl) begin
      chk("tbl_crit", crit_cap, v.exp_crit);
      if (reqq.size() > 0) chk("tbl_raddr0", reqq[0], v.exp_raddr0);
    end
  endtask

  vec_t tbl[6];
  vec_t rv;
  int   n;

  initial begin
    tbl[0] = '{32'h1C00_0008, -1, 0, 0, 0, 9,
               32'h1C00_0108, 32'h1C00_0008};
    tbl[1] = '{32'h1C00_0008, 1, 3, 0, 0, 12,
               32'h1C00_0108, 32'h1C00_0008};
    tbl[2] = '{32'h1C00_000C, -1, 0, 0, 1, 9,
               32'h1C00_010C, 32'h1C00_000C};
    tbl[3] = '{32'h2000_0000, -1, 0, 0, 0, 9,
               32'h2000_0100, 32'h2000_0000};
    tbl[4] = '{32'h1C00_0000, -1, 0, 0, 0, 9,
               32'h1C00_0100, 32'h1C00_0000};
    tbl[5] = '{32'h1C00_0004, -1, 0, 1, 0, 9,
               32'h1C00_0104, 32'h1C00_0004};

    @(negedge clk);
    #1;
    chk_reset_outs("rst");
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++)
      run_miss(tbl[i], 1'b1);

    // Wrap at top of address space.
    rv = '{32'hFFFF_FFFC, -1, 0, 0, 0, 9, 32'h0000_00FC, 32'hFFFF_FFFC};
    run_miss(rv, 1'b1);

    // Reset while waiting for the third beat.
    clear_obs();
    stall_idx = -1;
    spur = 0;
    rv_block_at = 2;
    miss_valid = 1'b1;
    miss_addr = 32'h1C00_0008;
    n = 0;
    while (!acc_seen && n < 50) begin
      step();
      n++;
    end
    miss_valid = 1'b0;
    n = 0;
    while (!(beats == 2 && cache_rready) && n < 100) begin
      step();
      n++;
    end
    chk("mid_wait_reached", 32'(beats == 2 && cache_rready), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_outs("abort");
    #1;
    step();
    step();
    reset = 1'b0;
    rv_block_at = -1;
    for (int i = 0; i < 6; i++) step();
    chk("abort_no_refill", refill_cnt, 32'd0);
    run_miss(tbl[0], 1'b1);

    // Randomised misses with random bridge timing.
    rand_mode = 1;
    for (int i = 0; i < 25; i++) begin
      salt = $urandom;
      rv = '{$urandom, -1, 0, 1'($urandom_range(0, 1)), 0, 0,
             32'd0, 32'd0};
      run_miss(rv, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
